// File: rtl/mem_port_arb.sv
// Arbitrates one single-ported memory between the fetch (I) and load/store (D) ports.
// One access is in flight at a time: stores complete in their issue cycle, reads wait out LAT cycles.
module mem_port_arb #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned LAT        = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_ready,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ready,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic          stall
);

   localparam int unsigned CW = $clog2(LAT + 1);
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] lat_q, lat_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          own_d_q, own_d_d;
   logic          grant_i, grant_d, i_starved;

   // State register; reset abandons any in-flight read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         lat_q    <= '0;
         starve_q <= '0;
         own_d_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         starve_q <= starve_d;
         own_d_q  <= own_d_d;
      end
   end

   // Arbitration, memory strobes, read return and next-state logic.
   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      starve_d  = starve_q;
      own_d_d   = own_d_q;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      m_en      = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      i_ready   = 1'b0;
      i_rdata   = '0;
      d_ready   = 1'b0;
      d_rdata   = '0;
      i_starved = i_req && (starve_q == SW'(STARVE_MAX));

      case (state_q)
         S_IDLE: begin
            // rst gates issue so every output except stall is 0 during reset
            if (rst) begin
               if (d_req && !i_starved) begin
                  grant_d = 1'b1;
               end else if (i_req) begin
                  grant_i = 1'b1;
               end
            end
            if (grant_d) begin
               m_en   = 1'b1;
               m_addr = d_addr;
               if (d_we) begin
                  m_we    = 1'b1;
                  m_wdata = d_wdata;
                  d_ready = 1'b1;
               end else begin
                  own_d_d = 1'b1;
                  lat_d   = CW'(LAT);
                  state_d = S_WAIT;
               end
            end else if (grant_i) begin
               m_en    = 1'b1;
               m_addr  = i_addr;
               own_d_d = 1'b0;
               lat_d   = CW'(LAT);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            lat_d = lat_q - CW'(1);
            // Data arrives now; a withdrawn (flushed) request just drops it.
            if (lat_q == CW'(1)) begin
               state_d = S_IDLE;
               if (own_d_q) begin
                  if (d_req) begin
                     d_ready = 1'b1;
                     d_rdata = m_rdata;
                  end
               end else if (i_req) begin
                  i_ready = 1'b1;
                  i_rdata = m_rdata;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (!i_req || grant_i) begin
         starve_d = '0;
      end else if (grant_d && (starve_q != SW'(STARVE_MAX))) begin
         starve_d = starve_q + SW'(1);
      end
   end

   assign stall = (i_req & ~i_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios then random traffic, every cycle checked
// against a timestamp-based transaction model with its own shadow memory.
module tb_mem_port_arb;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned LAT  = 2;
   localparam int unsigned SMAX = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, d_req, d_we;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata, m_rdata;
   logic [DW-1:0] i_rdata, d_rdata, m_wdata;
   logic [AW-1:0] m_addr;
   logic          i_ready, d_ready, m_en, m_we, stall;

   mem_port_arb #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .stall(stall)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;
   int cyc    = 0;

   // Reference model: one pending read described by its return cycle.
   logic          pend = 1'b0;
   logic          pend_is_d = 1'b0;
   int            pend_done = 0;
   logic [DW-1:0] pend_data = '0;
   int            streak = 0;
   logic          last_iry = 1'b0, last_dry = 1'b0;

   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   logic [DW-1:0] dev_mem [logic [AW-1:0]];
   logic [DW-1:0] ret [int];

   function automatic logic [DW-1:0] seed_val(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : seed_val(a);
   endfunction

   function automatic logic [DW-1:0] dev_rd(input logic [AW-1:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : seed_val(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
   endtask

   // One clock cycle: present inputs, predict, compare mid-cycle, let the memory react.
   task automatic step();
      logic          e_en, e_we, e_iry, e_dry, iw, dw;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata, e_ird, e_drd;
      m_rdata = ret.exists(cyc) ? ret[cyc] : $urandom();
      @(negedge clk);
      e_en = 1'b0; e_we = 1'b0; e_iry = 1'b0; e_dry = 1'b0; iw = 1'b0; dw = 1'b0;
      e_addr = '0; e_wdata = '0; e_ird = '0; e_drd = '0;
      if (!rst) begin
         pend   = 1'b0;
         streak = 0;
      end else begin
         if (pend && cyc == pend_done) begin
            if (pend_is_d && d_req) begin
               e_dry = 1'b1;
               e_drd = pend_data;
            end else if (!pend_is_d && i_req) begin
               e_iry = 1'b1;
               e_ird = pend_data;
            end
            pend = 1'b0;
         end else if (!pend) begin
            dw = d_req && !(i_req && streak >= int'(SMAX));
            iw = !dw && i_req;
            if (dw) begin
               e_en   = 1'b1;
               e_addr = d_addr;
               if (d_we) begin
                  e_we    = 1'b1;
                  e_wdata = d_wdata;
                  e_dry   = 1'b1;
                  ref_mem[d_addr] = d_wdata;
               end else begin
                  pend = 1'b1; pend_is_d = 1'b1;
                  pend_done = cyc + int'(LAT);
                  pend_data = ref_rd(d_addr);
               end
            end else if (iw) begin
               e_en   = 1'b1;
               e_addr = i_addr;
               pend = 1'b1; pend_is_d = 1'b0;
               pend_done = cyc + int'(LAT);
               pend_data = ref_rd(i_addr);
            end
         end
         if (!i_req || iw) streak = 0;
         else if (dw && streak < int'(SMAX)) streak++;
      end
      check("m_en",    32'(m_en),    32'(e_en));
      check("m_we",    32'(m_we),    32'(e_we));
      check("m_addr",  m_addr,       e_addr);
      check("m_wdata", m_wdata,      e_wdata);
      check("i_ready", 32'(i_ready), 32'(e_iry));
      check("i_rdata", i_rdata,      e_ird);
      check("d_ready", 32'(d_ready), 32'(e_dry));
      check("d_rdata", d_rdata,      e_drd);
      check("stall",   32'(stall),   32'((i_req & ~e_iry) | (d_req & ~e_dry)));
      // Memory device responds to what the DUT actually drives.
      if (m_en === 1'b1) begin
         if (m_we === 1'b1) dev_mem[m_addr] = m_wdata;
         else ret[cyc + int'(LAT)] = dev_rd(m_addr);
      end
      last_iry = e_iry;
      last_dry = e_dry;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
      ref_mem[32'h0000_3000] = 32'h8C01_0004;
      dev_mem[32'h0000_3000] = 32'h8C01_0004;
      step(); step();
      rst = 1'b1;
      step();

      // Single fetch, LAT=2.
      i_req = 1'b1; i_addr = 32'h0000_3000;
      repeat (3) step();
      i_req = 1'b0; step();

      // Simultaneous I and D load: D first, then I.
      i_req = 1'b1; i_addr = 32'h0000_0100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
      repeat (3) step();
      d_req = 1'b0;
      repeat (3) step();
      i_req = 1'b0; step();

      // Store completes in issue cycle, then read it back.
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2004; d_wdata = 32'h1234_5678;
      step();
      d_req = 1'b0; step();
      d_req = 1'b1; d_we = 1'b0;
      repeat (3) step();
      d_req = 1'b0; step();

      // Starvation: continuous D loads with I held.
      i_req = 1'b1; i_addr = 32'h0000_0040;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080;
      repeat (21) step();
      i_req = 1'b0; d_req = 1'b0; step();

      // Fetch flushed mid-wait; pending load issues once back in IDLE.
      i_req = 1'b1; i_addr = 32'h0000_0044;
      step();
      i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0084;
      repeat (5) step();
      d_req = 1'b0; step();

      // Reset during a wait; held fetch re-issues after release.
      i_req = 1'b1; i_addr = 32'h0000_0048;
      step();
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      repeat (3) step();
      i_req = 1'b0; step();

      // Random traffic with flushes and occasional resets.
      for (int k = 0; k < 600; k++) begin
         rst = ($urandom_range(0, 99) != 0);
         if (i_req && last_iry) i_req = 1'b0;
         if (d_req && last_dry) d_req = 1'b0;
         if (i_req && $urandom_range(0, 15) == 0) i_req = 1'b0;
         if (d_req && $urandom_range(0, 15) == 0) d_req = 1'b0;
         if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req  = 1'b1;
            i_addr = 32'($urandom_range(0, 15)) << 2;
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req   = 1'b1;
            d_we    = ($urandom_range(0, 2) == 0);
            d_addr  = 32'($urandom_range(0, 15)) << 2;
            d_wdata = $urandom();
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
